// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: formats load data, selects the writeback value and
// drives the register file write port from flops. Also counts retired instructions.
module mem_wb_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [4:0]      in_rd,
    input  logic            in_reg_write,
    input  logic [1:0]      in_wb_sel,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_load_data,
    input  logic [XLEN-1:0] in_pc_plus4,
    input  logic            stall,
    input  logic            flush,
    output logic [4:0]      writeReg,
    output logic [XLEN-1:0] writedata,
    output logic            RegWrite,
    output logic            wb_valid,
    output logic [31:0]     instret
);

    logic [1:0]      off;
    logic [7:0]      load_byte;
    logic [15:0]     load_half;
    logic [XLEN-1:0] load_fmt;
    logic [XLEN-1:0] wb_value;

    logic [4:0]      write_reg_d, write_reg_q;
    logic [XLEN-1:0] write_data_d, write_data_q;
    logic            reg_write_d, reg_write_q;
    logic            wb_valid_d, wb_valid_q;
    logic [31:0]     instret_d, instret_q;

    assign off = in_alu_result[1:0];

    always_comb begin
        load_byte = in_load_data[7:0];
        case (off)
            2'd0: load_byte = in_load_data[7:0];
            2'd1: load_byte = in_load_data[15:8];
            2'd2: load_byte = in_load_data[23:16];
            2'd3: load_byte = in_load_data[31:24];
            default: load_byte = in_load_data[7:0];
        endcase
        // Misaligned halfwords silently drop off[0]; no trap is raised here.
        load_half = off[1] ? in_load_data[31:16] : in_load_data[15:0];

        case (in_funct3)
            3'b000:  load_fmt = {{24{load_byte[7]}}, load_byte};
            3'b100:  load_fmt = {24'd0, load_byte};
            3'b001:  load_fmt = {{16{load_half[15]}}, load_half};
            3'b101:  load_fmt = {16'd0, load_half};
            default: load_fmt = in_load_data;
        endcase

        case (in_wb_sel)
            2'b01:   wb_value = load_fmt;
            2'b10:   wb_value = in_pc_plus4;
            default: wb_value = in_alu_result;
        endcase
    end

    always_comb begin
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        reg_write_d  = reg_write_q;
        wb_valid_d   = wb_valid_q;
        instret_d    = instret_q;
        if (flush) begin
            write_reg_d  = 5'd0;
            write_data_d = '0;
            reg_write_d  = 1'b0;
            wb_valid_d   = 1'b0;
        end else if (!stall) begin
            write_reg_d  = in_rd;
            write_data_d = wb_value;
            reg_write_d  = in_valid & in_reg_write & (in_rd != 5'd0);
            wb_valid_d   = in_valid;
            if (in_valid) begin
                instret_d = instret_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_reg_q  <= 5'd0;
            write_data_q <= '0;
            reg_write_q  <= 1'b0;
            wb_valid_q   <= 1'b0;
            instret_q    <= 32'd0;
        end else begin
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            reg_write_q  <= reg_write_d;
            wb_valid_q   <= wb_valid_d;
            instret_q    <= instret_d;
        end
    end

    assign writeReg  = write_reg_q;
    assign writedata = write_data_q;
    assign RegWrite  = reg_write_q;
    assign wb_valid  = wb_valid_q;
    assign instret   = instret_q;

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Pipeline register and writeback logic between the MEM stage and the register file. Captures one instruction per cycle from MEM. Formats load data by size, sign-extension and byte offset, then selects the writeback value. Drives the register file write port (`writeReg`, `writedata`, `RegWrite`) from flops, so these signals also serve as the WB-stage forwarding source. Also keeps a retired-instruction counter.

## Interface
Parameters:
- `XLEN`, 32, datapath width; only 32 is supported.

Ports:
- `clk`  in  1  system clock; all flops update on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  MEM holds a real instruction this cycle.
- `in_rd`  in  5  destination register index.
- `in_reg_write`  in  1  instruction writes `rd`.
- `in_wb_sel`  in  2  writeback source: 00 ALU, 01 load, 10 PC+4, 11 treated as ALU.
- `in_funct3`  in  3  load size and sign field.
- `in_alu_result`  in  32  ALU result; also the load address, and bits [1:0] give the byte offset.
- `in_load_data`  in  32  raw aligned word read from data memory.
- `in_pc_plus4`  in  32  link value for JAL/JALR.
- `stall`  in  1  hold the stage contents.
- `flush`  in  1  replace the captured entry with a bubble.
- `writeReg`  out  5  register file write index.
- `writedata`  out  32  register file write data.
- `RegWrite`  out  1  register file write enable.
- `wb_valid`  out  1  stage holds a valid instruction.
- `instret`  out  32  count of retired instructions.

## Operation
- Load formatting is combinational on the MEM-side inputs, before the register. With `off = in_alu_result[1:0]`:
  - 000 LB: byte `off`, sign-extended.
  - 100 LBU: byte `off`, zero-extended.
  - 001 LH: halfword `off[1]`, sign-extended.
  - 101 LHU: halfword `off[1]`, zero-extended.
  - 010 LW and all other codes: the full word; the offset is ignored.
  - Misaligned halfword (`off` = 1 or 3): `off[0]` is ignored. No trap is raised.
- Writeback mux: `in_wb_sel` selects the formatted load, `in_pc_plus4`, or `in_alu_result`.
- Capture priority at each rising edge, highest first:
  1. `reset`
  2. `flush`: `wb_valid` goes to 0, `RegWrite` to 0, `writeReg` to 0 and `writedata` to 0.
  3. `stall`: all flops hold.
  4. Normal: capture `in_valid` and the computed value.
- `RegWrite` is registered as `in_valid & in_reg_write & (in_rd != 0)`. A write to x0 never reaches the register file.
- `writeReg` and `writedata` are captured whatever the state of `RegWrite`. When `RegWrite` is 0 their values don't matter, except after reset or flush, where they are 0.
- `instret` increments by 1 on each normal capture where `in_valid` is 1. This includes instructions with rd = x0 and instructions that do not write.
  - It does not increment on stall, flush or bubbles.
  - It wraps from 0xFFFFFFFF to 0.
- During a stall the outputs are held, so the register file rewrites the same value each cycle. That write is idempotent and is required behaviour. `instret` counts the instruction once.

## Timing
- Latency is 1 cycle: MEM-side inputs sampled at edge N appear on the outputs after edge N.
- All outputs are driven directly from flops, with no combinational path from inputs to outputs.
- Reset values: `writeReg` 0, `writedata` 0, `RegWrite` 0, `wb_valid` 0, `instret` 0. Reset acts immediately when asserted, without waiting for a clock edge.
- Reset asserted mid-stall or mid-flush still clears everything. The first capture happens at the first rising edge after `reset` deasserts.
- `flush` and `stall` asserted together: flush wins and a bubble is captured.
- Back-to-back valid instructions: one is captured per cycle, with no bubbles inserted.
- Register file read-during-write ordering is the register file's responsibility. This stage only guarantees stable outputs for the full cycle.

## Test plan
- **Reset:** assert `reset` mid-cycle with arbitrary inputs -> all outputs 0 immediately. Deassert and apply an ALU op with rd=5, result 0x12345678 -> one edge later `RegWrite`=1, `writeReg`=5, `writedata`=0x12345678, `instret`=1.
- **Load formats:** `in_load_data`=0x80F07F81, wb_sel=01.
  - LB off 0 -> 0xFFFFFF81
  - LBU off 0 -> 0x00000081
  - LB off 1 -> 0x0000007F
  - LH off 2 -> 0xFFFF80F0
  - LHU off 2 -> 0x000080F0
  - LW off 3 -> 0x80F07F81
- **x0 and link:** JAL with rd=0 and pc_plus4=0x104 -> `RegWrite`=0 and `instret` increments. The same instruction with rd=1 -> `writedata`=0x104, `RegWrite`=1.
- **Stall:** capture an instruction (rd=3, data 0xA), then hold `stall` for 3 cycles while the inputs change -> outputs stay rd=3, data 0xA, `RegWrite`=1, and `instret` increments only once.
- **Flush:** assert `flush` and `stall` together with a valid write on the inputs -> `wb_valid`=0, `RegWrite`=0, `writeReg`=0, `writedata`=0, `instret` unchanged.
- **Counter wrap:** force `instret` to 0xFFFFFFFE through a sequence of valid captures (or preload in the bench), then apply 2 valid instructions -> `instret` goes 0xFFFFFFFF, then 0x00000000.
